div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-cycle restoring divider for the MIPS `DIV`/`DIVU` instructions. It sits in the execute stage, directly upstream of the HI/LO pipeline registers. Its `done` pulse drives their write enable, with `quotient` going to LO and `remainder` to HI. While `busy` is high, the hazard logic stalls the pipeline by deasserting the enables of the upstream stage registers.

## Interface
- `DATA_BITS`, default 32, operand and result width (must be ≥ 2).

- `clk` input 1: system clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a division; sampled only in IDLE.
- `is_signed` input 1: 1 = `DIV` (two's complement), 0 = `DIVU`.
- `dividend` input `DATA_BITS`: rs operand, sampled with `start`.
- `divisor` input `DATA_BITS`: rt operand, sampled with `start`.
- `quotient` output `DATA_BITS`: result destined for LO; registered.
- `remainder` output `DATA_BITS`: result destined for HI; registered.
- `busy` output 1: a division is in progress; registered.
- `done` output 1: one-cycle pulse meaning results are valid; registered.

## Operation
- **States:** IDLE, CALC, SIGN. Reset puts the unit in IDLE.
- **IDLE + `start`:** latch the operands.
  - Store the absolute values of both operands; take absolute values only when `is_signed` = 1.
  - Store the quotient sign (sign(dividend) XOR sign(divisor)), the remainder sign (sign(dividend)), the raw dividend, and a `div0` flag (divisor == 0).
  - Clear the partial remainder and the step counter, then go to CALC.
- **CALC:** perform one restoring step per cycle.
  - Shift the partial remainder left by one and bring in the next dividend MSB.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - After `DATA_BITS` steps, go to SIGN.
- **SIGN:** write the results, assert `done` for the next cycle, and return to IDLE.
  - Signed mode: negate the quotient or remainder when its stored sign bit is 1.
  - If `div0` is set, output `quotient` = all ones and `remainder` = raw dividend, in both modes. There is no trap.
- **Overflow:** the most-negative value divided by −1 gives `quotient` = most-negative value and `remainder` = 0. This is natural wrap with no flag.
- **Ignored requests:** `start` is ignored while `busy` = 1. Operand changes during CALC have no effect.
- **Output hold:** `quotient` and `remainder` hold their value until the next SIGN write.
- **Arithmetic width:** the partial remainder is `DATA_BITS`+1 bits wide so the trial subtract can show its sign. All negation is two's complement at `DATA_BITS` width.

## Timing
- **Reset values:** asserting `rst` at any time drives the following immediately, with no clock needed:
  - `quotient` = 0 and `remainder` = 0;
  - `busy` = 0 and `done` = 0;
  - state = IDLE.
- **Reset mid-operation:** an in-flight division is discarded and no `done` is produced.
- **Edge numbering:** let E0 be the edge that samples `start` in IDLE.
- **`busy`:** high from after E0 through E33, and low again in the `done` cycle.
- **CALC steps:** occur on edges E1 to E32.
- **SIGN write:** at E33. `done` = 1 in the cycle between E33 and E34, for exactly one cycle.
- **Latency:** 33 clocks from the start edge to valid results. Throughput is one division per 34 cycles.
- **Back-to-back:** `start` asserted during the `done` cycle is accepted at E34 (state is already IDLE). Results of the first division remain visible until the second division's SIGN write.
- **Zero-divisor timing:** division by zero takes the same latency as any other division.

## Structure
- **Shared package (`div_pkg`):**
  - the state enumeration (IDLE, CALC, SIGN);
  - a counter-width constant, `$clog2(DATA_BITS)`+1;
  - a function returning a two's-complement absolute value.
- **Sub-module `div_step`:** purely combinational. It takes the partial remainder, the incoming dividend bit and the divisor magnitude, and returns the next partial remainder and the quotient bit. CALC instantiates one copy.
- **Top level:** `div_unit` holds the FSM, the operand/sign registers, the counter and the output registers.

## Test plan
- **Unsigned:** `is_signed`=0, 100 / 7 → `quotient`=14, `remainder`=2; `done` high exactly 33 clocks after the start edge; `busy` high for 33 cycles.
- **Signed, negative dividend:** −7 / 2 → `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF. Also 7 / −2 → `quotient`=0xFFFFFFFD, `remainder`=1.
- **Signed overflow and unsigned reinterpretation:**
  - 0x80000000 / 0xFFFFFFFF signed → `quotient`=0x80000000, `remainder`=0.
  - The same operands unsigned → `quotient`=0, `remainder`=0x80000000.
- **Divide by zero:** 5 / 0 in both modes → `quotient`=0xFFFFFFFF, `remainder`=5, `done` at the normal latency.
- **Request handling:**
  - `start` with new operands pulsed at cycle 10 of a busy division → ignored, and the first result is correct.
  - `start` held high through the `done` cycle → the second division begins at E34, and its results appear 33 clocks later.
- **Asynchronous reset:** assert `rst` between edges during cycle 12 of CALC → all outputs go to 0 before the next edge. No `done` appears afterward, and a fresh start then completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: FSM states,
// counter sizing and two's-complement magnitude helper.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StSign
  } div_state_e;

  // Widest operand the magnitude helper handles; callers zero-extend into it.
  localparam int unsigned AbsMaxBits = 64;

  localparam int unsigned DefaultDataBits = 32;
  localparam int unsigned DefaultCntBits  = $clog2(DefaultDataBits) + 1;

  function automatic int unsigned cnt_width(input int unsigned data_bits);
    return $clog2(data_bits) + 1;
  endfunction

  // Magnitude of a two's-complement value; neg is the caller's sign bit
  // (already gated by signed mode), so the result wraps for the most-negative value.
  function automatic logic [AbsMaxBits-1:0] twos_abs(input logic [AbsMaxBits-1:0] val,
                                                     input logic                  neg);
    return neg ? -val : val;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor magnitude, keep the difference when it is non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32
) (
  input  logic [DATA_BITS:0]   rem_in,
  input  logic                 dvd_bit,
  input  logic [DATA_BITS-1:0] dvsr,
  output logic [DATA_BITS:0]   rem_out,
  output logic                 q_bit
);

  logic [DATA_BITS:0] shifted;
  logic [DATA_BITS:0] diff;
  // A kept partial remainder is always below the divisor, so its MSB is zero.
  logic               unused_rem_msb;

  assign unused_rem_msb = rem_in[DATA_BITS];

  always_comb begin
    shifted = {rem_in[DATA_BITS-1:0], dvd_bit};
    diff    = shifted - {1'b0, dvsr};
    q_bit   = ~diff[DATA_BITS];
    rem_out = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-step restoring divider for DIV/DIVU; results feed HI/LO and
// done acts as their write enable.
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [DATA_BITS-1:0] dividend,
  input  logic [DATA_BITS-1:0] divisor,
  output logic [DATA_BITS-1:0] quotient,
  output logic [DATA_BITS-1:0] remainder,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CntBits = cnt_width(DATA_BITS);

  div_state_e           state_q, state_d;
  logic [CntBits-1:0]   cnt_q, cnt_d;
  logic [DATA_BITS-1:0] dvd_q, dvd_d;
  logic [DATA_BITS-1:0] dvsr_q, dvsr_d;
  logic [DATA_BITS-1:0] raw_q, raw_d;
  logic [DATA_BITS:0]   rem_q, rem_d;
  logic [DATA_BITS-1:0] quo_q, quo_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  logic                 div0_q, div0_d;
  logic [DATA_BITS-1:0] quotient_q, quotient_d;
  logic [DATA_BITS-1:0] remainder_q, remainder_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 dvd_neg, dvsr_neg;
  logic [DATA_BITS-1:0] dvd_abs, dvsr_abs, rem_mag;
  logic [DATA_BITS:0]   step_rem;
  logic                 step_q;

  assign dvd_neg  = is_signed & dividend[DATA_BITS-1];
  assign dvsr_neg = is_signed & divisor[DATA_BITS-1];
  assign dvd_abs  = DATA_BITS'(twos_abs(AbsMaxBits'(dividend), dvd_neg));
  assign dvsr_abs = DATA_BITS'(twos_abs(AbsMaxBits'(divisor), dvsr_neg));
  assign rem_mag  = rem_q[DATA_BITS-1:0];

  div_step #(
    .DATA_BITS(DATA_BITS)
  ) u_step (
    .rem_in (rem_q),
    .dvd_bit(dvd_q[DATA_BITS-1]),
    .dvsr   (dvsr_q),
    .rem_out(step_rem),
    .q_bit  (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvsr_d      = dvsr_q;
    raw_d       = raw_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    div0_d      = div0_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          dvd_d   = dvd_abs;
          dvsr_d  = dvsr_abs;
          raw_d   = dividend;
          qneg_d  = dvd_neg ^ dvsr_neg;
          rneg_d  = dvd_neg;
          div0_d  = (divisor == '0);
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = {quo_q[DATA_BITS-2:0], step_q};
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q + CntBits'(1);
        if (cnt_q == CntBits'(DATA_BITS - 1)) begin
          state_d = StSign;
        end
      end
      StSign: begin
        if (div0_q) begin
          quotient_d  = '1;
          remainder_d = raw_q;
        end else begin
          quotient_d  = qneg_q ? -quo_q : quo_q;
          remainder_d = rneg_q ? -rem_mag : rem_mag;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvsr_q      <= '0;
      raw_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      div0_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvsr_q      <= dvsr_d;
      raw_q       <= raw_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      div0_q      <= div0_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed DIV/DIVU vectors, latency,
// request handling and asynchronous reset.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_bad;

  div_unit #(
    .DATA_BITS(32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .is_signed(is_signed),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .remainder(remainder),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one division and watch it to completion; poke injects a competing
  // start with new operands 10 cycles into the calculation.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_q,
                         input logic [31:0] exp_r, input bit poke);
    int cyc;
    int bcnt;
    @(negedge clk);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 0;
    bcnt  = 0;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      if (poke && cyc == 10) begin
        dividend = 32'h0001_2345;
        divisor  = 32'd3;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check_val({tag, "_lat"}, cyc, 32'd33);
    check_val({tag, "_busycyc"}, bcnt, 32'd33);
    check_val({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_q"}, quotient, exp_q);
    check_val({tag, "_r"}, remainder, exp_r);
    @(posedge clk);
    #1;
    check_val({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int cyc;
    int dcnt;
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check_val("rst0_q", quotient, 32'd0);
    check_val("rst0_r", remainder, 32'd0);
    check_val("rst0_busy", {31'd0, busy}, 32'd0);
    check_val("rst0_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    run_div("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    run_div("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_div("s_div0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
    run_div("u_div0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
    run_div("poke", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b1);

    // start held high through done: second division accepted at E34.
    @(negedge clk);
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd33;
    start     = 1'b1;
    @(posedge clk);
    #1;
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'd16;
    cyc      = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val("b2b_lat1", cyc, 32'd33);
    check_val("b2b_q1", quotient, 32'd30);
    check_val("b2b_r1", remainder, 32'd10);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_val("b2b_busy2", {31'd0, busy}, 32'd1);
    check_val("b2b_hold_q", quotient, 32'd30);
    cyc = 0;
    while (!done && cyc < 40) begin
      if (cyc == 20) check_val("b2b_hold_r", remainder, 32'd10);
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val("b2b_lat2", cyc, 32'd33);
    check_val("b2b_q2", quotient, 32'h0FFF_FFFF);
    check_val("b2b_r2", remainder, 32'd15);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    is_signed = 1'b1;
    dividend  = 32'h7FFF_FFFF;
    divisor   = 32'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_val("arst_q", quotient, 32'd0);
    check_val("arst_r", remainder, 32'd0);
    check_val("arst_busy", {31'd0, busy}, 32'd0);
    check_val("arst_done", {31'd0, done}, 32'd0);
    #1 rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
    end
    check_val("arst_no_done", dcnt, 32'd0);
    run_div("after_rst", 1'b1, 32'h7FFF_FFFF, 32'd3, 32'h2AAA_AAAA, 32'd1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
